// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: buffers one pulse request per client channel and serialises them onto a single
// downstream memory port with one transaction outstanding. Define ARB_FIXED_PRIORITY_EN for lowest-index-first grants.
module mem_port_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int SW    = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // Every handshake is a one-cycle pulse with no backpressure: a channel owns one slot, a request
    // into a busy slot is dropped and flagged in ch_overrun, and responses are never stalled.
    input  logic [NCH-1:0]        ch_request_enable,
    input  logic [NCH-1:0]        ch_req_mode,
    input  logic [NCH*ADDR_W-1:0] ch_req_addr,
    input  logic [NCH*DATA_W-1:0] ch_req_wdata,
    input  logic [NCH*SW-1:0]     ch_req_wstrb,
    output logic [NCH-1:0]        ch_response_enable,
    output logic [DATA_W-1:0]     ch_resp_data,
    output logic [NCH-1:0]        ch_overrun,
    output logic                  request_enable,
    output logic                  req_mode,
    output logic [ADDR_W-1:0]     req_addr,
    output logic [DATA_W-1:0]     req_wdata,
    output logic [SW-1:0]         req_wstrb,
    input  logic                  response_enable,
    input  logic [DATA_W-1:0]     resp_data,
    input  logic                  flush,
    output logic                  dbg_state
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     grant_q, sel;
    logic              found, start, done, aborted_q;
    logic [NCH-1:0]    pending_q, pending_d, pending_eff;
    logic [NCH-1:0]    inflight, release_m, overrun_set;

    logic              slot_mode  [NCH];
    logic [ADDR_W-1:0] slot_addr  [NCH];
    logic [DATA_W-1:0] slot_wdata [NCH];
    logic [SW-1:0]     slot_wstrb [NCH];

`ifndef ARB_FIXED_PRIORITY_EN
    logic [CW-1:0]     rr_last_q;
    logic [NCH-1:0]    rotated;
    logic [CW:0]       shamt;
    int                ch_idx;
`endif

    assign dbg_state = state_q;

    // A slot is free this cycle if it was empty, is being released, or is flushed while not in flight.
    always_comb begin
        inflight  = '0;
        release_m = '0;
        if (state_q == S_WAIT) inflight[grant_q] = 1'b1;
        done = (state_q == S_WAIT) && response_enable;
        if (done) release_m[grant_q] = 1'b1;
        pending_eff = pending_q & ~release_m & ~({NCH{flush}} & ~inflight);
        overrun_set = ch_request_enable & pending_eff;
        pending_d   = pending_eff | ch_request_enable;
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < NCH; k++) begin
            if (!found && pending_q[k]) begin
                found = 1'b1;
                sel   = CW'(k);
            end
        end
`else
        // Rotate so bit 0 is the channel after the last one served, then take the first set bit.
        shamt   = {1'b0, rr_last_q} + (CW+1)'(1);
        rotated = NCH'({pending_q, pending_q} >> shamt);
        ch_idx  = 0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && rotated[k]) begin
                found  = 1'b1;
                ch_idx = int'(rr_last_q) + 1 + k;
                if (ch_idx >= NCH) ch_idx = ch_idx - NCH;
                sel    = CW'(ch_idx);
            end
        end
`endif
        start = (state_q == S_IDLE) && found && !flush;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WAIT;
            S_WAIT:  if (response_enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            grant_q            <= '0;
            aborted_q          <= 1'b0;
            pending_q          <= '0;
            ch_overrun         <= '0;
            ch_response_enable <= '0;
            ch_resp_data       <= '0;
            request_enable     <= 1'b0;
            req_mode           <= 1'b0;
            req_addr           <= '0;
            req_wdata          <= '0;
            req_wstrb          <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_last_q          <= CW'(NCH - 1);
`endif
        end else begin
            state_q            <= state_d;
            pending_q          <= pending_d;
            ch_overrun         <= ch_overrun | overrun_set;
            request_enable     <= start;
            ch_response_enable <= '0;
            if (start) begin
                req_mode  <= slot_mode[sel];
                req_addr  <= slot_addr[sel];
                req_wdata <= slot_wdata[sel];
                req_wstrb <= slot_wstrb[sel];
                grant_q   <= sel;
                aborted_q <= 1'b0;
            end
            if (state_q == S_WAIT && flush) aborted_q <= 1'b1;
            if (done) begin
                // An aborted transaction still retires its response, silently.
                if (!aborted_q && !flush) begin
                    ch_response_enable[grant_q] <= 1'b1;
                    ch_resp_data                <= resp_data;
                end
`ifndef ARB_FIXED_PRIORITY_EN
                rr_last_q <= grant_q;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (ch_request_enable[k] && !pending_eff[k]) begin
                slot_mode[k]  <= ch_req_mode[k];
                slot_addr[k]  <= ch_req_addr[k*ADDR_W +: ADDR_W];
                slot_wdata[k] <= ch_req_wdata[k*DATA_W +: DATA_W];
                slot_wstrb[k] <= ch_req_wstrb[k*SW +: SW];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (NCH=3): directed scenarios with fixed expectations plus a randomized
// run checked cycle by cycle against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int NCH    = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SW     = DATA_W / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH-1:0]        ch_request_enable, ch_req_mode, ch_response_enable, ch_overrun;
    logic [NCH*ADDR_W-1:0] ch_req_addr;
    logic [NCH*DATA_W-1:0] ch_req_wdata;
    logic [NCH*SW-1:0]     ch_req_wstrb;
    logic [DATA_W-1:0]     ch_resp_data, req_wdata, resp_data;
    logic                  request_enable, req_mode, response_enable, flush, dbg_state;
    logic [ADDR_W-1:0]     req_addr;
    logic [SW-1:0]         req_wstrb;

    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W-1:0] exp_q[$];

    // reference model state and predicted outputs
    logic [NCH-1:0]    m_pend, m_ovr, e_rsp_en;
    logic              m_mode  [NCH];
    logic [ADDR_W-1:0] m_addr  [NCH];
    logic [DATA_W-1:0] m_wdata [NCH];
    logic [SW-1:0]     m_wstrb [NCH];
    bit                m_busy, m_abort;
    int                m_cur, m_last;
    logic              e_req_en, e_req_mode;
    logic [ADDR_W-1:0] e_req_addr;
    logic [DATA_W-1:0] e_req_wdata, e_rsp_data;
    logic [SW-1:0]     e_req_wstrb;

    mem_port_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ch_request_enable(ch_request_enable), .ch_req_mode(ch_req_mode),
        .ch_req_addr(ch_req_addr), .ch_req_wdata(ch_req_wdata), .ch_req_wstrb(ch_req_wstrb),
        .ch_response_enable(ch_response_enable), .ch_resp_data(ch_resp_data), .ch_overrun(ch_overrun),
        .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .response_enable(response_enable), .resp_data(resp_data), .flush(flush),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        ch_request_enable = '0; ch_req_mode = '0; ch_req_addr = '0; ch_req_wdata = '0;
        ch_req_wstrb = '0; response_enable = 1'b0; resp_data = '0; flush = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        ch_request_enable = '0;
        response_enable   = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic mode, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [SW-1:0] wstrb);
        ch_request_enable[ch]              = 1'b1;
        ch_req_mode[ch]                    = mode;
        ch_req_addr[ch*ADDR_W +: ADDR_W]   = addr;
        ch_req_wdata[ch*DATA_W +: DATA_W]  = wdata;
        ch_req_wstrb[ch*SW +: SW]          = wstrb;
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_pend = '0; m_ovr = '0; e_rsp_en = '0; m_busy = 0; m_abort = 0; m_cur = 0; m_last = NCH - 1;
        e_req_en = 0; e_req_mode = 0; e_req_addr = '0; e_req_wdata = '0; e_req_wstrb = '0; e_rsp_data = '0;
    endtask

    task automatic model_step();
        logic [NCH-1:0] pend_before;
        bit was_busy, found;
        int c;
        pend_before = m_pend;
        was_busy    = m_busy;
        found       = 0;
        e_req_en    = 1'b0;
        e_rsp_en    = '0;
        if (was_busy) begin
            if (response_enable) begin
                if (!m_abort && !flush) begin
                    e_rsp_en[m_cur] = 1'b1;
                    e_rsp_data      = resp_data;
                end
                m_pend[m_cur] = 1'b0;
                m_last        = m_cur;
                m_busy        = 0;
            end else if (flush) begin
                m_abort = 1;
            end
        end else if (!flush) begin
            for (int k = 0; k < NCH; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
                c = k;
`else
                c = (m_last + 1 + k) % NCH;
`endif
                if (!found && pend_before[c]) begin
                    found       = 1;
                    e_req_en    = 1'b1;
                    e_req_mode  = m_mode[c];
                    e_req_addr  = m_addr[c];
                    e_req_wdata = m_wdata[c];
                    e_req_wstrb = m_wstrb[c];
                    m_busy      = 1;
                    m_cur       = c;
                    m_abort     = 0;
                end
            end
        end
        if (flush)
            for (int i = 0; i < NCH; i++)
                if (!(was_busy && i == m_cur)) m_pend[i] = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_request_enable[i]) begin
                if (m_pend[i]) m_ovr[i] = 1'b1;
                else begin
                    m_pend[i]  = 1'b1;
                    m_mode[i]  = ch_req_mode[i];
                    m_addr[i]  = ch_req_addr[i*ADDR_W +: ADDR_W];
                    m_wdata[i] = ch_req_wdata[i*DATA_W +: DATA_W];
                    m_wstrb[i] = ch_req_wstrb[i*SW +: SW];
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (request_enable !== 1'b0) begin n_errors++; $display("FAIL reset_req_en got=%0b exp=0", request_enable); end
        n_checks++; if (ch_response_enable !== '0) begin n_errors++; $display("FAIL reset_ch_rsp got=%b exp=000", ch_response_enable); end
        n_checks++; if (ch_overrun !== '0) begin n_errors++; $display("FAIL reset_overrun got=%b exp=000", ch_overrun); end
        n_checks++; if ({req_mode, req_addr, req_wdata, req_wstrb} !== '0) begin n_errors++; $display("FAIL reset_req_fields got addr=%h wdata=%h", req_addr, req_wdata); end
        n_checks++; if (ch_resp_data !== '0) begin n_errors++; $display("FAIL reset_resp_data got=%h exp=0", ch_resp_data); end
        n_checks++; if (dbg_state !== 1'b0) begin n_errors++; $display("FAIL reset_state got=%0b exp=0", dbg_state); end
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(0, 1'b0, 32'h8000_1000, '0, '0);
        next_cycle();  // cycle 1
        n_checks++; if (request_enable !== 1'b0) begin n_errors++; $display("FAIL read_early_req got=%0b exp=0", request_enable); end
        next_cycle();  // cycle 2
        n_checks++; if (request_enable !== 1'b1) begin n_errors++; $display("FAIL read_req_en got=%0b exp=1", request_enable); end
        n_checks++; if (req_addr !== 32'h8000_1000) begin n_errors++; $display("FAIL read_req_addr got=%h exp=80001000", req_addr); end
        n_checks++; if (req_mode !== 1'b0) begin n_errors++; $display("FAIL read_req_mode got=%0b exp=0", req_mode); end
        next_cycle();  // cycle 3
        n_checks++; if (request_enable !== 1'b0) begin n_errors++; $display("FAIL read_req_pulse got=%0b exp=0", request_enable); end
        next_cycle();
        next_cycle();  // cycle 5
        response_enable = 1'b1;
        resp_data       = 32'hDEAD_BEEF;
        next_cycle();  // cycle 6
        n_checks++; if (ch_response_enable !== 3'b001) begin n_errors++; $display("FAIL read_ch_rsp got=%b exp=001", ch_response_enable); end
        n_checks++; if (ch_resp_data !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL read_rsp_data got=%h exp=deadbeef", ch_resp_data); end
        next_cycle();  // cycle 7
        n_checks++; if (ch_response_enable !== 3'b000) begin n_errors++; $display("FAIL read_rsp_pulse got=%b exp=000", ch_response_enable); end
        n_checks++; if (dbg_state !== 1'b0) begin n_errors++; $display("FAIL read_idle got=%0b exp=0", dbg_state); end
    endtask

    task automatic test_fairness();
        int resp_at;
        bit repulsed;
        logic [ADDR_W-1:0] exp_addr;
        do_reset();
        exp_q = {};
`ifdef ARB_FIXED_PRIORITY_EN
        exp_q.push_back(32'h1000); exp_q.push_back(32'h2000); exp_q.push_back(32'h1000); exp_q.push_back(32'h3000);
`else
        exp_q.push_back(32'h1000); exp_q.push_back(32'h2000); exp_q.push_back(32'h3000); exp_q.push_back(32'h1000);
`endif
        for (int i = 0; i < NCH; i++) set_req(i, 1'b0, 32'h1000 * (i + 1), '0, '0);
        resp_at  = -1;
        repulsed = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            next_cycle();
            if (request_enable) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL fair_extra_grant cyc=%0d got addr=%h exp=none", cyc, req_addr);
                end else begin
                    exp_addr = exp_q.pop_front();
                    if (req_addr !== exp_addr) begin n_errors++; $display("FAIL fair_order cyc=%0d got addr=%h exp=%h", cyc, req_addr, exp_addr); end
                end
                resp_at = cyc + 2;
            end
            if (ch_response_enable[0] && !repulsed) begin
                set_req(0, 1'b0, 32'h1000, '0, '0);
                repulsed = 1;
            end
            if (cyc == resp_at) begin
                response_enable = 1'b1;
                resp_data       = DATA_W'(cyc);
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL fair_missing got_left=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        int n_req, n_rsp;
        do_reset();
        set_req(1, 1'b0, 32'h2000, '0, '0);
        n_req = 0;
        n_rsp = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            next_cycle();
            if (request_enable) n_req++;
            if (ch_response_enable != '0) n_rsp++;
            if (cyc == 4) begin
                n_checks++; if (ch_overrun !== 3'b010) begin n_errors++; $display("FAIL ovr_set got=%b exp=010", ch_overrun); end
            end
            if (cyc == 3 || cyc == 5) set_req(1, 1'b0, 32'h2100, '0, '0);
            if (cyc == 8) response_enable = 1'b1;
        end
        n_checks++; if (n_req != 1) begin n_errors++; $display("FAIL ovr_req_count got=%0d exp=1", n_req); end
        n_checks++; if (n_rsp != 1) begin n_errors++; $display("FAIL ovr_rsp_count got=%0d exp=1", n_rsp); end
        n_checks++; if (ch_overrun !== 3'b010) begin n_errors++; $display("FAIL ovr_sticky got=%b exp=010", ch_overrun); end
        do_reset();
        n_checks++; if (ch_overrun !== 3'b000) begin n_errors++; $display("FAIL ovr_cleared got=%b exp=000", ch_overrun); end
    endtask

    task automatic test_write();
        do_reset();
        set_req(1, 1'b1, 32'h3000, 32'h1234_5678, 4'b0011);
        next_cycle();
        next_cycle();  // cycle 2
        n_checks++; if (request_enable !== 1'b1) begin n_errors++; $display("FAIL wr_req_en got=%0b exp=1", request_enable); end
        n_checks++; if (req_mode !== 1'b1) begin n_errors++; $display("FAIL wr_mode got=%0b exp=1", req_mode); end
        n_checks++; if (req_wdata !== 32'h1234_5678) begin n_errors++; $display("FAIL wr_wdata got=%h exp=12345678", req_wdata); end
        n_checks++; if (req_wstrb !== 4'b0011) begin n_errors++; $display("FAIL wr_wstrb got=%b exp=0011", req_wstrb); end
        n_checks++; if (req_addr !== 32'h3000) begin n_errors++; $display("FAIL wr_addr got=%h exp=3000", req_addr); end
        next_cycle();
        response_enable = 1'b1;
        next_cycle();
        n_checks++; if (ch_response_enable !== 3'b010) begin n_errors++; $display("FAIL wr_ch_rsp got=%b exp=010", ch_response_enable); end
    endtask

    task automatic test_flush();
        int n_req, n_rsp;
        do_reset();
        set_req(0, 1'b0, 32'h4000, '0, '0);
        next_cycle();  // cycle 1
        set_req(1, 1'b0, 32'h5000, '0, '0);
        next_cycle();  // cycle 2
        n_checks++; if (request_enable !== 1'b1 || req_addr !== 32'h4000) begin n_errors++; $display("FAIL flush_issue got en=%0b addr=%h exp en=1 addr=4000", request_enable, req_addr); end
        next_cycle();  // cycle 3
        flush = 1'b1;
        n_req = 0;
        n_rsp = 0;
        for (int cyc = 4; cyc <= 14; cyc++) begin
            next_cycle();
            if (request_enable) n_req++;
            if (ch_response_enable != '0) n_rsp++;
            if (cyc == 5) response_enable = 1'b1;
            if (cyc == 7) begin
                n_checks++; if (dbg_state !== 1'b0) begin n_errors++; $display("FAIL flush_idle got=%0b exp=0", dbg_state); end
            end
        end
        n_checks++; if (n_req != 0) begin n_errors++; $display("FAIL flush_no_issue got=%0d exp=0", n_req); end
        n_checks++; if (n_rsp != 0) begin n_errors++; $display("FAIL flush_no_rsp got=%0d exp=0", n_rsp); end
        set_req(1, 1'b0, 32'h5100, '0, '0);
        next_cycle();
        next_cycle();
        n_checks++; if (request_enable !== 1'b1 || req_addr !== 32'h5100) begin n_errors++; $display("FAIL flush_after got en=%0b addr=%h exp en=1 addr=5100", request_enable, req_addr); end
        n_checks++; if (ch_overrun !== 3'b000) begin n_errors++; $display("FAIL flush_overrun got=%b exp=000", ch_overrun); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(0, 1'b0, 32'h6000, '0, '0);
        next_cycle();
        next_cycle();  // cycle 2
        n_checks++; if (request_enable !== 1'b1 || req_addr !== 32'h6000) begin n_errors++; $display("FAIL b2b_first got en=%0b addr=%h exp en=1 addr=6000", request_enable, req_addr); end
        next_cycle();
        next_cycle();  // cycle 4
        response_enable = 1'b1;
        resp_data       = 32'hA5A5_5A5A;
        set_req(0, 1'b0, 32'h6100, '0, '0);
        next_cycle();  // cycle 5
        n_checks++; if (ch_response_enable !== 3'b001) begin n_errors++; $display("FAIL b2b_rsp got=%b exp=001", ch_response_enable); end
        n_checks++; if (ch_overrun !== 3'b000) begin n_errors++; $display("FAIL b2b_overrun got=%b exp=000", ch_overrun); end
        n_checks++; if (request_enable !== 1'b0) begin n_errors++; $display("FAIL b2b_gap got=%0b exp=0", request_enable); end
        next_cycle();  // cycle 6
        n_checks++; if (request_enable !== 1'b1 || req_addr !== 32'h6100) begin n_errors++; $display("FAIL b2b_second got en=%0b addr=%h exp en=1 addr=6100", request_enable, req_addr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_req(0, 1'b0, 32'h7000, '0, '0);
        next_cycle();
        next_cycle();  // cycle 2, transaction in WAIT
        next_cycle();
        rst = 1'b1;
        #1;
        n_checks++; if (dbg_state !== 1'b0 || request_enable !== 1'b0) begin n_errors++; $display("FAIL midrst_state got st=%0b en=%0b exp 0 0", dbg_state, request_enable); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        response_enable = 1'b1;
        resp_data       = 32'hBAD0_BAD0;
        next_cycle();
        n_checks++; if (ch_response_enable !== 3'b000) begin n_errors++; $display("FAIL midrst_stray got=%b exp=000", ch_response_enable); end
        set_req(0, 1'b0, 32'h7100, '0, '0);
        next_cycle();
        next_cycle();
        n_checks++; if (request_enable !== 1'b1 || req_addr !== 32'h7100) begin n_errors++; $display("FAIL midrst_issue got en=%0b addr=%h exp en=1 addr=7100", request_enable, req_addr); end
        response_enable = 1'b1;
        resp_data       = 32'h0BAD_F00D;
        next_cycle();
        n_checks++; if (ch_response_enable !== 3'b001 || ch_resp_data !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL midrst_rsp got=%b data=%h exp=001 0badf00d", ch_response_enable, ch_resp_data); end
    endtask

    task automatic test_random();
        int countdown;
        do_reset();
        model_reset();
        countdown = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) next_cycle();
            n_checks++; if (request_enable !== e_req_en) begin n_errors++; $display("FAIL rand_req_en cyc=%0d got=%0b exp=%0b", cyc, request_enable, e_req_en); end
            n_checks++; if ({req_mode, req_addr, req_wdata, req_wstrb} !== {e_req_mode, e_req_addr, e_req_wdata, e_req_wstrb}) begin
                n_errors++; $display("FAIL rand_req_fields cyc=%0d got m=%0b a=%h d=%h s=%h exp m=%0b a=%h d=%h s=%h", cyc,
                                     req_mode, req_addr, req_wdata, req_wstrb, e_req_mode, e_req_addr, e_req_wdata, e_req_wstrb);
            end
            n_checks++; if (ch_response_enable !== e_rsp_en) begin n_errors++; $display("FAIL rand_ch_rsp cyc=%0d got=%b exp=%b", cyc, ch_response_enable, e_rsp_en); end
            n_checks++; if (ch_resp_data !== e_rsp_data) begin n_errors++; $display("FAIL rand_rsp_data cyc=%0d got=%h exp=%h", cyc, ch_resp_data, e_rsp_data); end
            n_checks++; if (ch_overrun !== m_ovr) begin n_errors++; $display("FAIL rand_overrun cyc=%0d got=%b exp=%b", cyc, ch_overrun, m_ovr); end
            n_checks++; if (dbg_state !== m_busy) begin n_errors++; $display("FAIL rand_state cyc=%0d got=%0b exp=%0b", cyc, dbg_state, m_busy); end

            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 3) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom));
            flush = ($urandom_range(0, 29) == 0);
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    response_enable = 1'b1;
                    resp_data       = $urandom;
                end
            end else if ($urandom_range(0, 49) == 0) begin
                response_enable = 1'b1;
                resp_data       = $urandom;
            end
            if (e_req_en) countdown = $urandom_range(1, 4);
            model_step();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_fairness();
        test_overrun();
        test_write();
        test_flush();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the two-channel fetch/mem front end of the MMU.
- Accepts pulse-style requests from NCH independent clients (fetch, data, page-table walker, DMA, ...) and buffers one request per channel.
- Arbitrates the buffered requests onto the single downstream memory request/response port, with one transaction outstanding.
- Routes each response pulse back to the client that issued it; supports a flush that discards queued work.

Parameters:
- NCH, 2, number of client channels (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width SW = DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ch_request_enable  in  NCH  per-channel one-cycle request pulse.
- ch_req_mode  in  NCH  per-channel mode, 1 = write, 0 = read.
- ch_req_addr  in  NCH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_req_wdata  in  NCH*DATA_W  packed the same way.
- ch_req_wstrb  in  NCH*SW  packed the same way.
- ch_response_enable  out  NCH  one-cycle response pulse to the owning channel.
- ch_resp_data  out  DATA_W  response data, shared by all channels; valid only while a ch_response_enable bit is high.
- ch_overrun  out  NCH  sticky flag: the channel issued a request while its previous one was still pending.
- request_enable  out  1  downstream one-cycle request pulse.
- req_mode  out  1  downstream mode.
- req_addr  out  ADDR_W  downstream address.
- req_wdata  out  DATA_W  downstream write data.
- req_wstrb  out  SW  downstream write strobes.
- response_enable  in  1  downstream one-cycle response pulse.
- resp_data  in  DATA_W  downstream response data.
- flush  in  1  discard all queued, not-yet-issued requests.

Behaviour:
- Reset: all outputs 0, all pending bits 0, state IDLE, rr_last = NCH-1.
- Reset asserted mid-transaction abandons it; any later response_enable is ignored while state is IDLE.
- Capture: on ch_request_enable[i] with pending[i]==0, latch mode/addr/wdata/wstrb into slot i and set pending[i].
- If pending[i]==1 when ch_request_enable[i] arrives, the request is dropped and ch_overrun[i] is set. ch_overrun clears on reset only.
- pending[i] stays set from capture until its response is delivered or it is flushed. The in-flight channel is therefore also pending.
- State IDLE:
  - Candidates are pending channels.
  - Grant the first candidate searching from rr_last+1 upward, wrapping modulo NCH.
  - At the clock edge: register the slot onto the req_* outputs, pulse request_enable for exactly the next cycle, record grant, go to WAIT.
- State WAIT:
  - request_enable = 0 and req_* outputs hold their values.
  - On response_enable: at the edge, pulse ch_response_enable[grant] for one cycle, register resp_data into ch_resp_data, clear pending[grant], set rr_last = grant, go to IDLE.
- Latency: request pulse in cycle 0 gives request_enable in cycle 2 if the port is idle. response_enable in cycle k gives ch_response_enable in cycle k+1.
- Next issue: the earliest next request_enable is cycle k+2.
- Same-cycle capture and release: ch_request_enable[grant] in the same cycle as response_enable is accepted (no overrun); its new fields are captured at that edge.
- Flush:
  - Clears pending for every non-in-flight channel.
  - In WAIT, the in-flight transaction is marked aborted: its response is awaited, ch_response_enable is suppressed, then pending[grant] is cleared and the state returns to IDLE.
  - In IDLE, the grant evaluated in the same cycle is cancelled.
  - flush together with ch_request_enable[i] for a non-in-flight channel: the flush applies first and the new request is captured.
  - flush together with response_enable: the response is suppressed.
- No combinational path from ch_* inputs to downstream outputs, or from response_enable to ch_* outputs.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: grant is always the lowest-index pending channel; rr_last is not implemented.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single read, NCH=2: ch0 pulse with addr 0x80001000 in cycle 0 gives request_enable in cycle 2 with req_addr=0x80001000 and req_mode=0. response_enable in cycle 5 with resp_data=0xDEADBEEF gives ch_response_enable=2'b01 and ch_resp_data=0xDEADBEEF in cycle 6.
- Fairness, NCH=3: all three channels pulse in the same cycle, each response returned 2 cycles after its request. Grants are issued in order 0,1,2; re-pulsing ch0 after its response gives order 1,2,0 (with ARB_FIXED_PRIORITY_EN: ch0 first again).
- Overrun: ch1 pulses twice while its first request is in WAIT. Only one downstream request is issued and ch_overrun=2'b10 stays set until rst.
- Write path: ch1 write with wdata 0x12345678 and wstrb 4'b0011 gives exactly those values on req_wdata/req_wstrb with req_mode=1.
- Flush: ch0 in flight with ch1 pending, flush pulsed. ch1 is never issued. ch0's response_enable produces no ch_response_enable, and the state returns to IDLE.
- Reset mid-WAIT: assert rst, then deliver a stray response_enable. No ch_response_enable is produced and a subsequent ch0 request completes normally.
